// File: rtl/taillight_pkg.sv
// rtl/taillight_pkg.sv - shared switch indices and constants for the tail-light input conditioner
package taillight_pkg;

  typedef enum logic [1:0] {IN_LEFT, IN_RIGHT, IN_BRAKE, IN_HAZARD} in_idx_t;

  localparam int NUM_SW = 4;

  // Switches whose activation restarts the pattern sequence; brake only lights, it never re-phases.
  localparam logic [NUM_SW-1:0] RESTART_MASK = (NUM_SW'(1) << IN_LEFT)
                                             | (NUM_SW'(1) << IN_RIGHT)
                                             | (NUM_SW'(1) << IN_HAZARD);

endpackage

// File: rtl/taillight_input_cond_if.sv
// rtl/taillight_input_cond_if.sv - raw switch inputs and conditioned outputs of the input conditioner
interface taillight_input_cond_if;

  logic left_raw;
  logic right_raw;
  logic brake_raw;
  logic hazard_raw;
  logic left;
  logic right;
  logic brake;
  logic hazard;
  logic step;
  logic dimclk;

  // Switch/stimulus side: drives the raw switches, consumes the clean signals.
  modport master (
    output left_raw, right_raw, brake_raw, hazard_raw,
    input  left, right, brake, hazard, step, dimclk
  );

  // Conditioner side.
  modport slave (
    input  left_raw, right_raw, brake_raw, hazard_raw,
    output left, right, brake, hazard, step, dimclk
  );

endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchronizer plus stable-count debouncer for one switch
module switch_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic q
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s;
  logic [CW-1:0] cnt;

  // Bring the asynchronous switch into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= raw;
      s  <= s1;
    end
  end

  // Accept a new level only after it has differed from q for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (s == q) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      q   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/taillight_input_cond.sv
// rtl/taillight_input_cond.sv - debounced switches, pattern step pulse and dimmer PWM for the tail-light FSM
module taillight_input_cond
  import taillight_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int STEP_DIV   = 32,
  parameter int DIM_PERIOD = 8,
  parameter int DIM_DUTY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  taillight_input_cond_if.slave  sw
);

  localparam int SW_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PW_W = (DIM_PERIOD > 1) ? $clog2(DIM_PERIOD) : 1;
  localparam logic [SW_W-1:0] SCNT_MAX = SW_W'(STEP_DIV - 1);
  localparam logic [PW_W-1:0] PCNT_MAX = PW_W'(DIM_PERIOD - 1);

  logic [NUM_SW-1:0] raw;
  logic [NUM_SW-1:0] q;
  logic [NUM_SW-1:0] q_d;
  logic              restart;
  logic [SW_W-1:0]   scnt;
  logic [SW_W-1:0]   scnt_next;
  logic              step_r;
  logic [PW_W-1:0]   pcnt;
  logic [PW_W-1:0]   pcnt_next;
  logic              dim_r;

  assign raw[IN_LEFT]   = sw.left_raw;
  assign raw[IN_RIGHT]  = sw.right_raw;
  assign raw[IN_BRAKE]  = sw.brake_raw;
  assign raw[IN_HAZARD] = sw.hazard_raw;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk (clk),
      .rst (rst),
      .raw (raw[i]),
      .q   (q[i])
    );
  end

  assign sw.left   = q[IN_LEFT];
  assign sw.right  = q[IN_RIGHT];
  assign sw.brake  = q[IN_BRAKE];
  assign sw.hazard = q[IN_HAZARD];
  assign sw.step   = step_r;
  assign sw.dimclk = dim_r;

  // Any number of simultaneous activations collapse into one restart.
  assign restart   = |(q & ~q_d & RESTART_MASK);
  assign scnt_next = (scnt == SCNT_MAX) ? '0 : scnt + 1'b1;
  assign pcnt_next = (pcnt == PCNT_MAX) ? '0 : pcnt + 1'b1;

  // Step divider; a fresh turn/hazard activation re-phases it so the first step is a full period away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_d    <= '0;
      scnt   <= '0;
      step_r <= 1'b0;
    end else begin
      q_d <= q;
      if (restart) begin
        scnt   <= '0;
        step_r <= 1'b0;
      end else begin
        scnt   <= scnt_next;
        step_r <= (scnt_next == SCNT_MAX);
      end
    end
  end

  // Free-running dimmer PWM; compared as int so DIM_DUTY == DIM_PERIOD yields a constant high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt  <= '0;
      dim_r <= 1'b0;
    end else begin
      pcnt  <= pcnt_next;
      dim_r <= (int'(pcnt_next) < DIM_DUTY);
    end
  end

endmodule

// File: tb/tb_taillight_input_cond.sv
// tb/tb_taillight_input_cond.sv - directed self-checking bench for taillight_input_cond
module tb_taillight_input_cond;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;
  int   ec = 0;

  taillight_input_cond_if bus0 ();
  taillight_input_cond_if bus_d0 ();
  taillight_input_cond_if bus_d4 ();

  taillight_input_cond #(.DEB_CYCLES(4), .STEP_DIV(8), .DIM_PERIOD(4), .DIM_DUTY(1)) u_dut (
    .clk (clk), .rst (rst), .sw (bus0)
  );
  taillight_input_cond #(.DEB_CYCLES(4), .STEP_DIV(8), .DIM_PERIOD(4), .DIM_DUTY(0)) u_dut_d0 (
    .clk (clk), .rst (rst), .sw (bus_d0)
  );
  taillight_input_cond #(.DEB_CYCLES(4), .STEP_DIV(8), .DIM_PERIOD(4), .DIM_DUTY(4)) u_dut_d4 (
    .clk (clk), .rst (rst), .sw (bus_d4)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic set_raw(input logic l, input logic r, input logic b, input logic h);
    bus0.left_raw   = l;
    bus0.right_raw  = r;
    bus0.brake_raw  = b;
    bus0.hazard_raw = h;
  endtask

  task automatic wait_step(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus0.step === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] o;
    set_raw(1, 1, 1, 1);
    rst = 1'b0;
    repeat (3) tick();
    o = {bus0.left, bus0.right, bus0.brake, bus0.hazard, bus0.step, bus0.dimclk, bus_d0.dimclk, bus_d4.dimclk};
    total++;
    if (o !== 8'h00) $display("FAIL reset_hold: got %b expected %b", o, 8'h00);
    else pass_cnt++;
    rst = 1'b1;
    ec = 0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      o[3:0] = {bus0.left, bus0.right, bus0.brake, bus0.hazard};
      if (e == 5) begin
        total++;
        if (o[3:0] !== 4'b0000) $display("FAIL reset_release_e5: got %b expected %b", o[3:0], 4'b0000);
        else pass_cnt++;
      end
      if (e == 6) begin
        total++;
        if (o[3:0] !== 4'b1111) $display("FAIL reset_release_e6: got %b expected %b", o[3:0], 4'b1111);
        else pass_cnt++;
      end
      total++;
      if (bus0.step !== (e == 14)) $display("FAIL reset_step_e%0d: got %b expected %b", e, bus0.step, (e == 14));
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch;
    bus0.left_raw = 1'b0;
    repeat (6) tick();
    total++;
    if (bus0.left !== 1'b0) $display("FAIL glitch_prep: got %b expected 0", bus0.left);
    else pass_cnt++;
    bus0.left_raw = 1'b1;
    repeat (3) tick();
    bus0.left_raw = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      total++;
      if (bus0.left !== 1'b0) $display("FAIL glitch_t%0d: got %b expected 0", t, bus0.left);
      else pass_cnt++;
    end
    bus0.left_raw = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t >= 5) begin
        total++;
        if (bus0.left !== (t == 6)) $display("FAIL glitch_hold_t%0d: got %b expected %b", t, bus0.left, (t == 6));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_step_restart;
    logic found;
    bus0.hazard_raw = 1'b0;
    repeat (6) tick();
    total++;
    if (bus0.hazard !== 1'b0) $display("FAIL restart_prep: got %b expected 0", bus0.hazard);
    else pass_cnt++;
    wait_step(found);
    total++;
    if (found !== 1'b1) $display("FAIL restart_sync: got %b expected 1 (no step in 20 cycles)", found);
    else pass_cnt++;
    bus0.hazard_raw = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      tick();
      if (t == 5 || t == 6) begin
        total++;
        if (bus0.hazard !== (t == 6)) $display("FAIL restart_hazard_t%0d: got %b expected %b", t, bus0.hazard, (t == 6));
        else pass_cnt++;
      end
      total++;
      if (bus0.step !== (t == 14 || t == 22))
        $display("FAIL restart_step_t%0d: got %b expected %b", t, bus0.step, (t == 14 || t == 22));
      else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous;
    logic found;
    bus0.left_raw  = 1'b0;
    bus0.right_raw = 1'b0;
    bus0.brake_raw = 1'b0;
    repeat (6) tick();
    total++;
    if ({bus0.left, bus0.right, bus0.brake} !== 3'b000)
      $display("FAIL simul_prep: got %b expected 000", {bus0.left, bus0.right, bus0.brake});
    else pass_cnt++;
    wait_step(found);
    total++;
    if (found !== 1'b1) $display("FAIL simul_sync: got %b expected 1 (no step in 20 cycles)", found);
    else pass_cnt++;
    bus0.left_raw  = 1'b1;
    bus0.right_raw = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 6) begin
        total++;
        if ({bus0.left, bus0.right} !== 2'b11) $display("FAIL simul_lr: got %b expected 11", {bus0.left, bus0.right});
        else pass_cnt++;
      end
      total++;
      if (bus0.step !== (t == 14)) $display("FAIL simul_step_t%0d: got %b expected %b", t, bus0.step, (t == 14));
      else pass_cnt++;
    end
    bus0.brake_raw = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 6) begin
        total++;
        if (bus0.brake !== 1'b1) $display("FAIL brake_rise: got %b expected 1", bus0.brake);
        else pass_cnt++;
      end
      total++;
      if (bus0.step !== (t == 8 || t == 16))
        $display("FAIL brake_step_t%0d: got %b expected %b", t, bus0.step, (t == 8 || t == 16));
      else pass_cnt++;
    end
  endtask

  task automatic test_pwm;
    int highs = 0;
    for (int t = 0; t < 16; t++) begin
      tick();
      highs += int'(bus0.dimclk);
      total++;
      if (bus0.dimclk !== (ec % 4 == 0)) $display("FAIL pwm_phase_ec%0d: got %b expected %b", ec, bus0.dimclk, (ec % 4 == 0));
      else pass_cnt++;
      total++;
      if (bus_d0.dimclk !== 1'b0) $display("FAIL pwm_duty0: got %b expected 0", bus_d0.dimclk);
      else pass_cnt++;
      total++;
      if (bus_d4.dimclk !== 1'b1) $display("FAIL pwm_duty4: got %b expected 1", bus_d4.dimclk);
      else pass_cnt++;
    end
    total++;
    if (highs != 4) $display("FAIL pwm_count: got %0d expected 4", highs);
    else pass_cnt++;
  endtask

  task automatic test_midop_reset;
    logic [5:0] o;
    bus0.hazard_raw = 1'b0;
    repeat (6) tick();
    total++;
    if ({bus0.left, bus0.right, bus0.brake, bus0.hazard} !== 4'b1110)
      $display("FAIL midrst_prep: got %b expected 1110", {bus0.left, bus0.right, bus0.brake, bus0.hazard});
    else pass_cnt++;
    bus0.hazard_raw = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    o = {bus0.left, bus0.right, bus0.brake, bus0.hazard, bus0.step, bus0.dimclk};
    total++;
    if (o !== 6'b0) $display("FAIL midrst_clear: got %b expected 000000", o);
    else pass_cnt++;
    repeat (2) tick();
    rst = 1'b1;
    ec = 0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t >= 5) begin
        total++;
        if ({bus0.left, bus0.right, bus0.brake, bus0.hazard} !== ((t == 6) ? 4'b1111 : 4'b0000))
          $display("FAIL midrst_t%0d: got %b expected %b", t,
                   {bus0.left, bus0.right, bus0.brake, bus0.hazard}, ((t == 6) ? 4'b1111 : 4'b0000));
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus_d0.left_raw = 1'b0; bus_d0.right_raw = 1'b0; bus_d0.brake_raw = 1'b0; bus_d0.hazard_raw = 1'b0;
    bus_d4.left_raw = 1'b0; bus_d4.right_raw = 1'b0; bus_d4.brake_raw = 1'b0; bus_d4.hazard_raw = 1'b0;
    set_raw(0, 0, 0, 0);
    test_reset();
    test_glitch();
    test_step_restart();
    test_simultaneous();
    test_pwm();
    test_midop_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
